// File: rtl/nv_ram_rwsp_pinit.sv
// nv_ram_rwsp_pinit: parametrised 1R1W RAM with read latency 2 (registered address,
// gated output register), hardware init/clear sequencer, read-valid flag and optional bypass.
module nv_ram_rwsp_pinit #(
    parameter int            DW       = 16,
    parameter int            AW       = 6,
    parameter int            DEPTH    = 64,
    parameter int            BYPASS   = 1,
    parameter logic [DW-1:0] INIT_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] ra,
    input  logic          re,
    input  logic          ore,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [DW-1:0] di,
    input  logic          clr,
    output logic          init_busy,
    input  logic [31:0]   pwrbus_ram_pd
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Counter is one bit wider than the address so DEPTH == 2^AW is representable.
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] LAST_W  = DEPTH_W - {{AW{1'b0}}, 1'b1};

    state_t        r_state;
    logic [AW:0]   r_icnt;
    logic [AW-1:0] r_ra_d;
    logic          r_rd_pend;
    logic [DW-1:0] r_dout;
    logic          r_dout_vld;
    logic          r_init_busy;
    logic [DW-1:0] r_mem [DEPTH];

    logic          w_ready;
    logic          w_wr_ok;
    logic          w_ra_ok;
    logic          w_collide;
    logic [DW-1:0] w_rdata;
    logic [DW-1:0] w_dout_nxt;
    logic          w_unused_pd;

    assign w_ready     = (r_state == ST_READY);
    assign w_wr_ok     = w_ready && we && ({1'b0, wa} < DEPTH_W);
    assign w_ra_ok     = ({1'b0, r_ra_d} < DEPTH_W);
    assign w_collide   = w_wr_ok && ore && (wa == r_ra_d);
    assign w_unused_pd = ^pwrbus_ram_pd;

    // Array read and collision select feeding the output register.
    always_comb begin
        w_rdata    = {DW{1'b0}};
        w_dout_nxt = {DW{1'b0}};
        if (w_ra_ok) begin
            w_rdata = r_mem[r_ra_d];
        end else begin
            w_rdata = {DW{1'b0}};
        end
        if (w_collide && (BYPASS != 0)) begin
            w_dout_nxt = di;
        end else begin
            w_dout_nxt = w_rdata;
        end
    end

    // Storage array (not reset): sequencer owns the write port while initialising.
    always_ff @(posedge clk) begin
        if (!w_ready) begin
            r_mem[r_icnt[AW-1:0]] <= INIT_VAL;
        end else if (w_wr_ok) begin
            r_mem[wa] <= di;
        end
    end

    // Init/ready FSM, read address pipeline and output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_INIT;
            r_icnt      <= {(AW+1){1'b0}};
            r_ra_d      <= {AW{1'b0}};
            r_rd_pend   <= 1'b0;
            r_dout      <= {DW{1'b0}};
            r_dout_vld  <= 1'b0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rd_pend <= 1'b0;
                    if (r_icnt == LAST_W) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end else begin
                        r_icnt <= r_icnt + {{AW{1'b0}}, 1'b1};
                    end
                end
                ST_READY: begin
                    if (re) begin
                        r_ra_d    <= ra;
                        r_rd_pend <= 1'b1;
                    end else begin
                        r_rd_pend <= 1'b0;
                    end
                    // The clr cycle itself is still serviced above.
                    if (clr) begin
                        r_state     <= ST_INIT;
                        r_icnt      <= {(AW+1){1'b0}};
                        r_init_busy <= 1'b1;
                    end else begin
                        r_state <= ST_READY;
                    end
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_icnt      <= {(AW+1){1'b0}};
                    r_rd_pend   <= 1'b0;
                    r_init_busy <= 1'b1;
                end
            endcase
            if (ore) begin
                r_dout     <= w_dout_nxt;
                r_dout_vld <= w_ready && r_rd_pend;
            end else begin
                r_dout     <= r_dout;
                r_dout_vld <= r_dout_vld;
            end
        end
    end

    assign dout      = r_dout;
    assign dout_vld  = r_dout_vld;
    assign init_busy = r_init_busy;

endmodule

// File: tb/tb_nv_ram_rwsp_pinit.sv
// Scoreboard bench for nv_ram_rwsp_pinit: u0 uses defaults (DEPTH 64, bypass on),
// u1 uses DEPTH 48 with bypass off; both share one stimulus stream.
module tb_nv_ram_rwsp_pinit;

    logic        clk = 1'b0;
    logic        rstn;
    logic [5:0]  ra, wa;
    logic        re, ore, we, clr;
    logic [15:0] di;
    logic [31:0] pwr;
    logic [15:0] dout0, dout1;
    logic        vld0, vld1, busy0, busy1;

    always #5 clk = ~clk;

    nv_ram_rwsp_pinit #(.DW(16), .AW(6), .DEPTH(64), .BYPASS(1), .INIT_VAL(16'h0000)) u0 (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout0), .dout_vld(vld0),
        .wa(wa), .we(we), .di(di), .clr(clr), .init_busy(busy0), .pwrbus_ram_pd(pwr));

    nv_ram_rwsp_pinit #(.DW(16), .AW(6), .DEPTH(48), .BYPASS(0), .INIT_VAL(16'h0000)) u1 (
        .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore), .dout(dout1), .dout_vld(vld1),
        .wa(wa), .we(we), .di(di), .clr(clr), .init_busy(busy1), .pwrbus_ram_pd(pwr));

    typedef struct {
        logic [15:0] d0;
        logic        v0;
        logic [15:0] d1;
        logic        v1;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;
    logic ore_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    // Monitor: an ore at the previous edge means the output register was reloaded.
    always @(posedge clk) ore_seen <= ore;

    always @(negedge clk) begin
        if (ore_seen) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'(sbq.size()), 32'd1);
            end else begin
                mon_e = sbq.pop_front();
                chk({mon_e.tag, "_dout0"}, 32'(dout0), 32'(mon_e.d0));
                chk({mon_e.tag, "_vld0"},  32'(vld0),  32'(mon_e.v0));
                chk({mon_e.tag, "_dout1"}, 32'(dout1), 32'(mon_e.d1));
                chk({mon_e.tag, "_vld1"},  32'(vld1),  32'(mon_e.v1));
            end
        end
    end

    task automatic step(input logic i_we, input logic [5:0] i_wa, input logic [15:0] i_di,
                        input logic i_re, input logic [5:0] i_ra, input logic i_ore, input logic i_clr,
                        input string tag, input logic [15:0] e0d, input logic e0v,
                        input logic [15:0] e1d, input logic e1v);
        exp_t e;
        we = i_we; wa = i_wa; di = i_di; re = i_re; ra = i_ra; ore = i_ore; clr = i_clr;
        if (i_ore) begin
            e.d0 = e0d; e.v0 = e0v; e.d1 = e1d; e.v1 = e1v; e.tag = tag;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b0, "", 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    // Follows init_busy over one init window; mode 1 adds INIT-time ore/we/re/clr probes.
    task automatic busy_window(input string tag, input int mode);
        for (int j = 0; j <= 64; j++) begin
            chk({tag, "_busy0"}, 32'(busy0), 32'(j < 64));
            chk({tag, "_busy1"}, 32'(busy1), 32'(j < 48));
            if (mode == 1 && j == 0)
                step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, {tag, "_initload"},
                     16'h5555, 1'b0, 16'h5555, 1'b0);
            else if (mode == 1 && j == 2)
                step(1'b1, 6'd7, 16'h1234, 1'b1, 6'd7, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
            else if (mode == 1 && j == 10)
                step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b1, "", 16'h0, 1'b0, 16'h0, 1'b0);
            else
                idle();
        end
    endtask

    task automatic read_all(input string tag);
        for (int k = 0; k < 64; k++)
            step(1'b0, 6'd0, 16'h0000, 1'b1, 6'(k), 1'b1, 1'b0, tag,
                 16'h0000, (k != 0), 16'h0000, (k != 0));
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, {tag, "_last"}, 16'h0000, 1'b1, 16'h0000, 1'b1);
        idle();
    endtask

    initial begin
        rstn = 1'b0; we = 1'b0; wa = 6'd0; di = 16'h0000; re = 1'b0; ra = 6'd0;
        ore = 1'b0; clr = 1'b0; pwr = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout0", 32'(dout0), 32'h0); chk("rst_vld0", 32'(vld0), 32'h0);
        chk("rst_busy0", 32'(busy0), 32'h1); chk("rst_dout1", 32'(dout1), 32'h0);
        chk("rst_vld1", 32'(vld1), 32'h0);   chk("rst_busy1", 32'(busy1), 32'h1);
        rstn = 1'b1;
        busy_window("init", 0);
        read_all("initrd");

        // Basic write then read; output register holds until ore.
        step(1'b1, 6'd5, 16'hBEEF, 1'b0, 6'd0, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b1, 6'd5, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        chk("hold_dout0", 32'(dout0), 32'h0); chk("hold_vld0", 32'(vld0), 32'h1);
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, "rw", 16'hBEEF, 1'b1, 16'hBEEF, 1'b1);

        // Address 50 is beyond u1's depth: write dropped, read returns zero.
        step(1'b1, 6'd50, 16'h7777, 1'b0, 6'd0, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b1, 6'd50, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, "oor", 16'h7777, 1'b1, 16'h0000, 1'b1);

        // Collision: u0 bypasses new data, u1 returns old data; follow-up ore sees new data.
        step(1'b1, 6'd9, 16'h1111, 1'b0, 6'd0, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b1, 6'd9, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b1, 6'd9, 16'h2222, 1'b0, 6'd0, 1'b1, 1'b0, "coll", 16'h2222, 1'b1, 16'h1111, 1'b1);
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, "coll2", 16'h2222, 1'b0, 16'h2222, 1'b0);

        // Write and read the same address in one cycle: read sees the new word.
        step(1'b1, 6'd12, 16'h3C3C, 1'b1, 6'd12, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, "wr_rd", 16'h3C3C, 1'b1, 16'h3C3C, 1'b1);

        // Fill with 0xAAAA, then clear while writing and reading word 3 in the clr cycle.
        for (int k = 0; k < 64; k++)
            step(1'b1, 6'(k), 16'hAAAA, 1'b0, 6'd0, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b1, 6'd40, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, "fill", 16'hAAAA, 1'b1, 16'hAAAA, 1'b1);
        step(1'b1, 6'd3, 16'h5555, 1'b1, 6'd3, 1'b0, 1'b1, "", 16'h0, 1'b0, 16'h0, 1'b0);
        busy_window("clr", 1);
        read_all("clrrd");

        // Async reset in the middle of a clear sequence (icnt == 20).
        step(1'b1, 6'd1, 16'h0F0F, 1'b0, 6'd0, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b1, 6'd1, 1'b0, 1'b0, "", 16'h0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b1, 1'b0, "pre_rst", 16'h0F0F, 1'b1, 16'h0F0F, 1'b1);
        step(1'b0, 6'd0, 16'h0000, 1'b0, 6'd0, 1'b0, 1'b1, "", 16'h0, 1'b0, 16'h0, 1'b0);
        repeat (20) idle();
        #3 rstn = 1'b0;
        #1;
        chk("arst_dout0", 32'(dout0), 32'h0); chk("arst_vld0", 32'(vld0), 32'h0);
        chk("arst_busy0", 32'(busy0), 32'h1); chk("arst_dout1", 32'(dout1), 32'h0);
        chk("arst_vld1", 32'(vld1), 32'h0);   chk("arst_busy1", 32'(busy1), 32'h1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        busy_window("reinit", 0);
        read_all("rstrd");

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
